// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between EX/MEM and the 2 KB synchronous data memory.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned loads into two aligned word reads.
module lsu_ctrl #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_stall,
   output logic [2:0]        mem_op,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic [4:0]        rsp_rd,
   output logic              err_valid,
   output logic [1:0]        err_cause,
   output logic [31:0]       err_addr,
   output logic              busy
);
   localparam logic [2:0] LOAD_WORD = 3'b110;

   typedef enum logic [2:0] {IDLE, ACCESS, ACC1, RESP, ERR} state_t;

   state_t            state_q, state_d, load_nxt;
   logic              we_q, uns_q;
   logic [1:0]        size_q, cause_q, req_sz, cause_d;
   logic [31:0]       addr_q, wdata_q, raw, ext;
   logic [4:0]        rd_q;
   logic [2:0]        mem_op_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mis, oor, fault, accept;
`ifdef LSU_MISALIGN_SPLIT_EN
   logic              split_q, split_d;
   logic [31:0]       w0_q;
`endif

   always_comb begin
      req_sz = req_size == 2'b11 ? 2'b10 : req_size;
      mis = (req_sz == 2'b01 && req_addr[0]) || (req_sz == 2'b10 && req_addr[1:0] != 2'b00);
      oor = |req_addr[31:ADDR_W];
      accept = req_valid && state_q == IDLE;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_d = mis && !req_we;
      // the second word of a split load must also fall inside the memory
      fault = (mis && req_we) || oor || (split_d && &req_addr[ADDR_W-1:2]);
      cause_d = mis && req_we ? 2'b10 : 2'b11;
      load_nxt = split_q ? ACC1 : RESP;
`else
      fault = mis || oor;
      cause_d = mis ? (req_we ? 2'b10 : 2'b01) : 2'b11;
      load_nxt = RESP;
`endif
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;

   always_comb begin
      state_d = state_q == IDLE   ? (!req_valid ? IDLE : fault ? ERR : ACCESS)
              : state_q == ACCESS ? (we_q ? IDLE : load_nxt)
              : state_q == ACC1   ? RESP : IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= 2'b00;
         cause_q    <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         mem_op_q   <= LOAD_WORD;
         mem_addr_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
         split_q    <= 1'b0;
         w0_q       <= '0;
`endif
      end else begin
         if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_sz;
            cause_q <= cause_d;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            if (!fault) begin
               mem_op_q   <= {~req_we, req_sz};
               mem_addr_q <= req_addr[ADDR_W-1:0];
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= split_d;
            if (!fault && split_d) begin
               mem_op_q   <= LOAD_WORD;
               mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            end
`endif
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         if (state_q == ACCESS && split_q) mem_addr_q <= mem_addr_q + ADDR_W'(4);
         if (state_q == ACC1) w0_q <= mem_rdata;
`endif
      end

   // memory already sign-extends sub-word loads; re-extending is harmless and covers split merges
   always_comb begin
      raw = mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (split_q) raw = 32'({mem_rdata, w0_q} >> {addr_q[1:0], 3'b000});
`endif
      ext = size_q == 2'b00 ? {{24{!uns_q && raw[7]}}, raw[7:0]}
          : size_q == 2'b01 ? {{16{!uns_q && raw[15]}}, raw[15:0]} : raw;
   end

   always_comb begin
      req_ready = state_q == IDLE;
      busy      = state_q != IDLE;
      mem_stall = !(state_q == ACCESS || state_q == ACC1);
      mem_op    = mem_op_q;
      mem_addr  = mem_addr_q;
      mem_wdata = wdata_q;
      rsp_valid = state_q == RESP;
      rsp_rdata = state_q == RESP ? ext : '0;
      rsp_rd    = state_q == RESP ? rd_q : '0;
      err_valid = state_q == ERR;
      err_cause = state_q == ERR ? cause_q : 2'b00;
      err_addr  = state_q == ERR ? addr_q : '0;
   end
endmodule
